// File: rtl/header_nonce_feeder.sv
// header_nonce_feeder
// Loads an 80-byte block header from a byte stream into 20 big-endian 32-bit
// words and serves them to a downstream double-SHA256 hasher. Word NONCE_IDX
// is replaced by a live nonce counter. After each hash the result is checked
// against a leading-zero difficulty: a hit is reported, otherwise the nonce is
// incremented and the hasher is restarted until the nonce space runs out.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   load_valid/load_data  header byte stream, byte 0 first
//   load_ready            byte accepted this cycle (IDLE/LOAD only)
//   run                   start / continue the nonce search
//   abort                 synchronous return to IDLE from any state
//   zbits                 required leading zero bits, latched on run
//   start                 one-cycle start pulse to the hasher
//   rq/addr -> data/rdy   hasher word requests, answered one cycle later
//   hash/done             hasher result and completion level
//   found/exhausted       search outcome flags, held
//   nonce_out             current (or winning) nonce
//   busy                  search in progress
module header_nonce_feeder #(
    parameter int HDR_WORDS = 20,
    parameter int NONCE_IDX = 19
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_valid,
    input  logic [7:0]   load_data,
    output logic         load_ready,
    input  logic         run,
    input  logic         abort,
    input  logic [7:0]   zbits,
    output logic         start,
    input  logic         rq,
    input  logic [4:0]   addr,
    output logic [31:0]  data,
    output logic         rdy,
    input  logic [255:0] hash,
    input  logic         done,
    output logic         found,
    output logic         exhausted,
    output logic [31:0]  nonce_out,
    output logic         busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_READY   = 3'd2,
        ST_START   = 3'd3,
        ST_WAIT    = 3'd4,
        ST_CHECK   = 3'd5,
        ST_FOUND   = 3'd6,
        ST_EXHAUST = 3'd7
    } state_t;

    localparam logic [6:0] LAST_BYTE = 7'(HDR_WORDS * 4 - 1);

    state_t        state_r;
    logic [6:0]    byte_cnt_r;
    logic [31:0]   hdr_r [HDR_WORDS];
    logic [31:0]   nonce_r;
    logic [7:0]    zbits_r;
    logic          rq_q_r;
    logic          done_q_r;
    logic          start_r;
    logic          rdy_r;
    logic [31:0]   data_r;
    logic          found_r;
    logic          exhausted_r;
    logic          busy_r;

    logic          rq_edge_s;
    logic          done_edge_s;
    logic          load_acc_s;
    logic [31:0]   served_word_s;
    logic [255:0]  zmask_s;
    logic          hash_pass_s;

    assign load_ready  = (state_r == ST_IDLE) || (state_r == ST_LOAD);
    assign load_acc_s  = load_valid & load_ready & ~abort;
    assign rq_edge_s   = rq & ~rq_q_r;
    assign done_edge_s = done & ~done_q_r;

    assign start     = start_r;
    assign rdy       = rdy_r;
    assign data      = data_r;
    assign found     = found_r;
    assign exhausted = exhausted_r;
    assign nonce_out = nonce_r;
    assign busy      = busy_r;

    // Word lookup for a hasher request: nonce substitution and out-of-range zero.
    always_comb begin
        served_word_s = 32'h0000_0000;
        if (addr == 5'(NONCE_IDX)) begin
            served_word_s = nonce_r;
        end else if (addr < 5'(HDR_WORDS)) begin
            served_word_s = hdr_r[addr];
        end else begin
            served_word_s = 32'h0000_0000;
        end
    end

    // Difficulty test: the top zbits bits of the hash must all be zero.
    always_comb begin
        zmask_s     = ~({256{1'b1}} >> zbits_r);
        hash_pass_s = ((hash & zmask_s) == 256'd0);
    end

    // Edge-detect history for the hasher's rq and done levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq_q_r   <= 1'b0;
            done_q_r <= 1'b0;
        end else begin
            rq_q_r   <= rq;
            done_q_r <= done;
        end
    end

    // Header storage: byte k lands in word k/4, most significant byte first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HDR_WORDS; i++) begin
                hdr_r[i] <= 32'h0000_0000;
            end
        end else if (load_acc_s) begin
            case (byte_cnt_r[1:0])
                2'd0:    hdr_r[byte_cnt_r[6:2]][31:24] <= load_data;
                2'd1:    hdr_r[byte_cnt_r[6:2]][23:16] <= load_data;
                2'd2:    hdr_r[byte_cnt_r[6:2]][15:8]  <= load_data;
                2'd3:    hdr_r[byte_cnt_r[6:2]][7:0]   <= load_data;
                default: hdr_r[byte_cnt_r[6:2]][7:0]   <= load_data;
            endcase
        end
    end

    // Main control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            byte_cnt_r  <= 7'd0;
            nonce_r     <= 32'h0000_0000;
            zbits_r     <= 8'd0;
            start_r     <= 1'b0;
            rdy_r       <= 1'b0;
            data_r      <= 32'h0000_0000;
            found_r     <= 1'b0;
            exhausted_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (abort) begin
            // Header words and the nonce counter are kept; a pending request is dropped.
            state_r     <= ST_IDLE;
            byte_cnt_r  <= 7'd0;
            start_r     <= 1'b0;
            rdy_r       <= 1'b0;
            found_r     <= 1'b0;
            exhausted_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            start_r <= 1'b0;
            rdy_r   <= 1'b0;
            case (state_r)
                ST_IDLE, ST_LOAD: begin
                    if (load_valid) begin
                        if (byte_cnt_r == LAST_BYTE) begin
                            // The final byte completes the nonce word; seed the counter from it.
                            state_r    <= ST_READY;
                            byte_cnt_r <= 7'd0;
                            nonce_r    <= {hdr_r[NONCE_IDX][31:8], load_data};
                        end else begin
                            state_r    <= ST_LOAD;
                            byte_cnt_r <= byte_cnt_r + 7'd1;
                        end
                    end
                end
                ST_READY: begin
                    if (run) begin
                        state_r     <= ST_START;
                        start_r     <= 1'b1;
                        busy_r      <= 1'b1;
                        zbits_r     <= zbits;
                        found_r     <= 1'b0;
                        exhausted_r <= 1'b0;
                    end
                end
                ST_START: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (rq_edge_s) begin
                        rdy_r  <= 1'b1;
                        data_r <= served_word_s;
                    end
                    if (done_edge_s) begin
                        state_r <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (hash_pass_s) begin
                        state_r <= ST_FOUND;
                        found_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else if (nonce_r == 32'hFFFF_FFFF) begin
                        state_r     <= ST_EXHAUST;
                        exhausted_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= ST_START;
                        start_r <= 1'b1;
                        nonce_r <= nonce_r + 32'd1;
                    end
                end
                ST_FOUND, ST_EXHAUST: begin
                    // Resume from the next nonce; from EXHAUST this wraps to zero.
                    if (run) begin
                        state_r     <= ST_START;
                        start_r     <= 1'b1;
                        busy_r      <= 1'b1;
                        zbits_r     <= zbits;
                        found_r     <= 1'b0;
                        exhausted_r <= 1'b0;
                        nonce_r     <= nonce_r + 32'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_header_nonce_feeder.sv
// Self-checking bench for header_nonce_feeder: table-driven word reads on the
// genesis header, a behavioural hasher/search model, randomized headers and
// difficulties, plus abort and mid-search reset sequences.
module tb_header_nonce_feeder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_valid = 1'b0;
    logic [7:0]   load_data = 8'h00;
    logic         load_ready;
    logic         run = 1'b0;
    logic         abort = 1'b0;
    logic [7:0]   zbits = 8'd0;
    logic         start;
    logic         rq = 1'b0;
    logic [4:0]   addr = 5'd0;
    logic [31:0]  data;
    logic         rdy;
    logic [255:0] hash = 256'd0;
    logic         done = 1'b0;
    logic         found;
    logic         exhausted;
    logic [31:0]  nonce_out;
    logic         busy;

    header_nonce_feeder dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .run(run), .abort(abort), .zbits(zbits),
        .start(start), .rq(rq), .addr(addr), .data(data), .rdy(rdy),
        .hash(hash), .done(done), .found(found), .exhausted(exhausted),
        .nonce_out(nonce_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int start_cnt = 0;

    logic [7:0]  hdr_b [80];
    logic [31:0] m_nonce;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [9];

    always @(negedge clk) if (start === 1'b1) start_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int a);
        if (a == 19) return m_nonce;
        if (a >= 20) return 32'h0;
        return {hdr_b[4*a], hdr_b[4*a+1], hdr_b[4*a+2], hdr_b[4*a+3]};
    endfunction

    function automatic int lzc(input logic [255:0] h);
        int n;
        n = 0;
        for (int i = 255; i >= 0; i--) begin
            if (h[i]) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [255:0] make_hash(input int mode, input logic [31:0] n);
        case (mode)
            0: return {n, 224'h0};
            1: return (n == 32'h1DAC2B7F) ? 256'h0 : {8'h80, 248'h0};
            2: return {1'b1, 255'h0};
            default: return {$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom};
        endcase
    endfunction

    task automatic load_hdr();
        chk("load_ready_before_load", {31'd0, load_ready}, 32'd1);
        for (int k = 0; k < 80; k++) begin
            load_valid = 1'b1;
            load_data  = hdr_b[k];
            tick();
        end
        load_valid = 1'b0;
        chk("load_ready_after_79", {31'd0, load_ready}, 32'd0);
        m_nonce = {hdr_b[76], hdr_b[77], hdr_b[78], hdr_b[79]};
    endtask

    task automatic read_word(input logic [4:0] a, input string name, output logic [31:0] got);
        rq   = 1'b1;
        addr = a;
        tick();
        chk({name, "_rdy"}, {31'd0, rdy}, 32'd1);
        chk(name, data, model_word(int'(a)));
        got = data;
        rq = 1'b0;
        tick();
        chk({name, "_rdy_single"}, {31'd0, rdy}, 32'd0);
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_start: got no start pulse expected start within 20 cycles");
        end
    endtask

    // reads: 0 none, 1 genesis table on first pass, 2 random addresses on first pass
    task automatic search(input logic [7:0] zb, input int mode, input int reads,
                          input bit same, input int exp_passes);
        int base, passes;
        bit fin, ok, pass;
        logic [31:0] got;
        logic [255:0] h;
        base = start_cnt;
        passes = 0;
        fin = 1'b0;
        zbits = zb;
        run = 1'b1;
        tick();
        run = 1'b0;
        while (!fin && passes < 300) begin
            wait_start(ok);
            if (!ok) return;
            chk("busy_in_start", {31'd0, busy}, 32'd1);
            tick();
            chk("start_single_cycle", {31'd0, start}, 32'd0);
            if (passes == 0 && reads == 1) begin
                for (int i = 0; i < 9; i++) begin
                    chk("table_model", tbl[i].exp, model_word(int'(tbl[i].a)));
                    read_word(tbl[i].a, $sformatf("tbl_word%0d", tbl[i].a), got);
                end
            end
            if (passes == 0 && reads == 2) begin
                for (int i = 0; i < 6; i++) begin
                    logic [4:0] ra;
                    ra = 5'($urandom_range(0, 31));
                    read_word(ra, $sformatf("rand_word%0d", ra), got);
                end
            end
            read_word(5'd19, "nonce_word", got);
            h = make_hash(mode, got);
            pass = (lzc(h) >= int'(zb));
            hash = h;
            done = 1'b1;
            if (same) begin
                rq   = 1'b1;
                addr = 5'd0;
            end
            tick();
            if (same) begin
                chk("same_edge_rdy", {31'd0, rdy}, 32'd1);
                chk("same_edge_data", data, model_word(0));
            end
            rq = 1'b0;
            done = 1'b0;
            tick();
            passes++;
            if (pass) begin
                chk("found", {31'd0, found}, 32'd1);
                chk("found_excl", {31'd0, exhausted}, 32'd0);
                chk("found_nonce", nonce_out, m_nonce);
                chk("found_busy", {31'd0, busy}, 32'd0);
                fin = 1'b1;
            end else if (m_nonce == 32'hFFFF_FFFF) begin
                chk("exhausted", {31'd0, exhausted}, 32'd1);
                chk("exh_found", {31'd0, found}, 32'd0);
                chk("exh_nonce", nonce_out, 32'hFFFF_FFFF);
                fin = 1'b1;
            end else begin
                m_nonce = m_nonce + 32'd1;
                chk("nonce_track", nonce_out, m_nonce);
            end
        end
        if (!fin) begin
            n_checks++;
            n_errors++;
            $display("FAIL search_budget: got %0d passes expected a result", passes);
        end
        chk("start_pulses", 32'(start_cnt - base), 32'(passes));
        if (exp_passes >= 0) chk("pass_count", 32'(passes), 32'(exp_passes));
    endtask

    initial begin
        logic [255:0] merkle;
        logic [31:0] got;
        int base;
        bit ok;

        tbl[0] = '{5'd0,  32'h0100_0000};
        tbl[1] = '{5'd1,  32'h0000_0000};
        tbl[2] = '{5'd8,  32'h0000_0000};
        tbl[3] = '{5'd9,  32'h3BA3_EDFD};
        tbl[4] = '{5'd17, 32'h29AB_5F49};
        tbl[5] = '{5'd18, 32'hFFFF_001D};
        tbl[6] = '{5'd19, 32'h1DAC_2B7C};
        tbl[7] = '{5'd20, 32'h0000_0000};
        tbl[8] = '{5'd31, 32'h0000_0000};

        merkle = 256'h3BA3EDFD7A7B12B27AC72C3E67768F617FC81BC3888A51323A9FB8AA4B1E5E4A;
        for (int k = 0; k < 80; k++) hdr_b[k] = 8'h00;
        hdr_b[0] = 8'h01;
        for (int i = 0; i < 32; i++) hdr_b[36+i] = merkle[255-8*i -: 8];
        hdr_b[68] = 8'h29; hdr_b[69] = 8'hAB; hdr_b[70] = 8'h5F; hdr_b[71] = 8'h49;
        hdr_b[72] = 8'hFF; hdr_b[73] = 8'hFF; hdr_b[74] = 8'h00; hdr_b[75] = 8'h1D;
        hdr_b[76] = 8'h1D; hdr_b[77] = 8'hAC; hdr_b[78] = 8'h2B; hdr_b[79] = 8'h7C;

        // reset state
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_rdy", {31'd0, rdy}, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_found", {31'd0, found}, 32'd0);
        chk("rst_exhausted", {31'd0, exhausted}, 32'd0);
        chk("rst_nonce", nonce_out, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd1);

        // genesis header, zbits=0, table reads
        load_hdr();
        chk("ready_nonce", nonce_out, 32'h1DAC_2B7C);
        search(8'd0, 0, 1, 1'b0, 1);
        chk("genesis_nonce", nonce_out, 32'h1DAC_2B7C);

        // abort clears flags, reload, zbits=8 needs four passes
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_found", {31'd0, found}, 32'd0);
        load_hdr();
        search(8'd8, 1, 0, 1'b1, 4);
        chk("zb8_nonce", nonce_out, 32'h1DAC_2B7F);

        // continue from FOUND with random difficulty and random hashes
        m_nonce = m_nonce + 32'd1;
        search(8'($urandom_range(0, 4)), 3, 0, 1'b0, -1);

        // abort during a pending request
        abort = 1'b1; tick(); abort = 1'b0;
        for (int k = 0; k < 80; k++) hdr_b[k] = 8'($urandom);
        load_hdr();
        zbits = 8'd0;
        run = 1'b1; tick(); run = 1'b0;
        wait_start(ok);
        tick();
        rq = 1'b1; addr = 5'd3; abort = 1'b1;
        tick();
        chk("abort_rdy", {31'd0, rdy}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_load_ready", {31'd0, load_ready}, 32'd1);
        chk("abort_start", {31'd0, start}, 32'd0);
        rq = 1'b0; abort = 1'b0;
        tick();
        chk("abort_no_late_rdy", {31'd0, rdy}, 32'd0);
        // byte offered together with abort is dropped
        load_valid = 1'b1; load_data = 8'hAA; abort = 1'b1;
        tick();
        load_valid = 1'b0; abort = 1'b0;

        // random header ending in FFFFFFFE, never passes -> exhaustion
        for (int k = 0; k < 76; k++) hdr_b[k] = 8'($urandom);
        hdr_b[76] = 8'hFF; hdr_b[77] = 8'hFF; hdr_b[78] = 8'hFF; hdr_b[79] = 8'hFE;
        load_hdr();
        search(8'd255, 2, 2, 1'b0, 2);
        m_nonce = m_nonce + 32'd1;
        search(8'd0, 0, 0, 1'b0, 1);
        chk("wrap_nonce", nonce_out, 32'd0);

        // reset pulsed during CHECK
        m_nonce = m_nonce + 32'd1;
        zbits = 8'd0;
        run = 1'b1; tick(); run = 1'b0;
        wait_start(ok);
        tick();
        read_word(5'd19, "pre_reset_word", got);
        hash = 256'h0; done = 1'b1;
        tick();
        base = start_cnt;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_start", {31'd0, start}, 32'd0);
        chk("mid_rst_rdy", {31'd0, rdy}, 32'd0);
        chk("mid_rst_data", data, 32'd0);
        chk("mid_rst_found", {31'd0, found}, 32'd0);
        chk("mid_rst_nonce", nonce_out, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_load_ready", {31'd0, load_ready}, 32'd1);
        done = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("post_rst_no_start", 32'(start_cnt - base), 32'd0);
        chk("post_rst_load_ready", {31'd0, load_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
